hazard_scheduler: RTL

//  In-order issue controller for the 9-stage processor pipeline. It sits beside the decode stage.
//  It keeps a per-register write scoreboard, stalls fetch when a RAW hazard exists, and inserts bubbles into ID/EX.
//  It also sequences start / halt / drain of the whole pipeline.

---
 rtl/proc_pkg.sv | 45 ++++
 rtl/sb_counter.sv | 39 +++
 rtl/hazard_scheduler.sv | 82 ++++++++
 3 files changed

// File: rtl/proc_pkg.sv
// Shared processor definitions: register-file geometry, opcode map, sequencer states
// and the operand/destination decode table used by the issue logic, cu and eu.
package proc_pkg;

    localparam int NUM_REGS = 8;
    localparam int REG_AW   = $clog2(NUM_REGS);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ALU  = 4'h1;
    localparam logic [3:0] OP_ALUI = 4'h2;
    localparam logic [3:0] OP_LD   = 4'h3;
    localparam logic [3:0] OP_ST   = 4'h4;
    localparam logic [3:0] OP_BR   = 4'h5;
    localparam logic [3:0] OP_LUI  = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    function automatic logic op_writes_reg(input logic [3:0] op);
        case (op)
            OP_ALU, OP_ALUI, OP_LD, OP_LUI: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    function automatic logic op_reads_a(input logic [3:0] op);
        case (op)
            OP_ALU, OP_ALUI, OP_LD, OP_ST, OP_BR: return 1'b1;
            default:                              return 1'b0;
        endcase
    endfunction

    function automatic logic op_reads_b(input logic [3:0] op);
        case (op)
            OP_ALU, OP_ST, OP_BR: return 1'b1;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sb_counter.sv
// Per-register write scoreboard entry: down-counter of cycles until the pending
// writeback is visible in the register file.
module sb_counter #(
    parameter int WB_LAT = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec_en,
    output logic busy
);

    localparam int CW = $clog2(WB_LAT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The issue cycle is the first of the WB_LAT cycles, so the counter holds
    // the remaining ones; a reader then issues exactly WB_LAT cycles later.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CW'(WB_LAT - 1);
        end else if (dec_en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_scheduler.sv
// In-order issue controller beside decode: RAW scoreboard, fetch stall / ID-EX bubble
// generation, start/halt/drain sequencing and a saturating stall counter.
module hazard_scheduler
    import proc_pkg::*;
#(
    parameter int WB_LAT = 6,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                halt_req,
    input  logic                id_valid,
    input  logic [3:0]          id_opcode,
    input  logic [REG_AW-1:0]   id_opa,
    input  logic [REG_AW-1:0]   id_opb,
    input  logic [REG_AW-1:0]   id_dest,
    output logic                iu_ce,
    output logic                id_hold,
    output logic                ex_bubble,
    output logic                issue,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic                halted,
    output logic [CNT_W-1:0]    stall_cnt
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             run;
    logic             haz;

    assign run = (state_q == ST_RUN);

    // WAW on a busy destination is deliberately not a hazard: issue is in order.
    assign haz = id_valid & ((op_reads_a(id_opcode) & busy_mask[id_opa]) |
                             (op_reads_b(id_opcode) & busy_mask[id_opb]));

    assign issue     = run & id_valid & ~haz;
    assign iu_ce     = run & ~haz;
    assign id_hold   = ~iu_ce;
    assign ex_bubble = ~issue;
    assign halted    = (state_q == ST_HALTED);
    assign stall_cnt = stall_cnt_q;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_sb
        sb_counter #(.WB_LAT(WB_LAT)) u_sb (
            .clk    (clk),
            .reset  (reset),
            .load   (issue & op_writes_reg(id_opcode) & (id_dest == REG_AW'(r))),
            .dec_en (1'b1),
            .busy   (busy_mask[r])
        );
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_HALTED: if (start && !halt_req) state_d = ST_RUN;
            ST_RUN:             if (halt_req) state_d = ST_DRAIN;
            ST_DRAIN:           if (busy_mask == '0) state_d = ST_HALTED;
            default:            state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (run && haz && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
